// File: rtl/pb_conditioner.sv
// Pushbutton conditioner: synchronizer, debounce FSM, press/release/long-press pulses, press counter.
// Long-press detection (lcnt, pb_long) is built only when PB_LONG_PRESS_EN is defined.
module pb_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 270000,
    parameter int unsigned LONG_CYCLES     = 27000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pb_in,
    output logic       pb_level,
    output logic       pb_press,
    output logic       pb_release,
    output logic       pb_long,
    output logic [7:0] press_cnt
);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 32'h000F_FFFF ||
        LONG_CYCLES <= DEBOUNCE_CYCLES || LONG_CYCLES > 32'h03FF_FFFF) begin : g_param_check
        $error("pb_conditioner: DEBOUNCE_CYCLES/LONG_CYCLES out of range");
    end

    localparam logic [19:0] DC_LAST = 20'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic        s1_q, s2_q;
    logic [19:0] dcnt_q, dcnt_d;
    logic        level_q, level_d;
    logic        press_q, press_d;
    logic        release_q, release_d;
    logic [7:0]  cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            state_q   <= IDLE;
            dcnt_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            s1_q      <= pb_in;
            s2_q      <= s1_q;
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (s2_q) begin
                    state_d = PRESS_WAIT;
                    dcnt_d  = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s2_q) begin
                    state_d = IDLE;
                end else begin
                    dcnt_d = dcnt_q + 20'd1;
                    if (dcnt_q == DC_LAST) begin
                        state_d = PRESSED;
                        level_d = 1'b1;
                        press_d = 1'b1;
                        cnt_d   = cnt_q + 8'd1;
                    end
                end
            end
            PRESSED: begin
                if (!s2_q) begin
                    state_d = RELEASE_WAIT;
                    dcnt_d  = '0;
                end
            end
            RELEASE_WAIT: begin
                if (s2_q) begin
                    state_d = PRESSED;
                end else begin
                    dcnt_d = dcnt_q + 20'd1;
                    if (dcnt_q == DC_LAST) begin
                        state_d   = IDLE;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef PB_LONG_PRESS_EN
    localparam logic [25:0] LC_MAX  = 26'(LONG_CYCLES);
    localparam logic [25:0] LC_LAST = 26'(LONG_CYCLES - 1);

    logic [25:0] lcnt_q, lcnt_d;
    logic        long_q, long_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lcnt_q <= '0;
            long_q <= 1'b0;
        end else begin
            lcnt_q <= lcnt_d;
            long_q <= long_d;
        end
    end

    // Saturation at LONG_CYCLES guarantees a single pulse per press, even across release glitches.
    always_comb begin
        lcnt_d = lcnt_q;
        long_d = 1'b0;
        if (press_d) begin
            lcnt_d = '0;
        end else if ((state_q == PRESSED || state_q == RELEASE_WAIT) && lcnt_q != LC_MAX) begin
            lcnt_d = lcnt_q + 26'd1;
            long_d = (lcnt_q == LC_LAST);
        end
    end

    assign pb_long = long_q;
`else
    assign pb_long = 1'b0;
`endif

    assign pb_level   = level_q;
    assign pb_press   = press_q;
    assign pb_release = release_q;
    assign press_cnt  = cnt_q;

endmodule

// File: tb/tb_pb_conditioner.sv
// Scoreboard bench for pb_conditioner (DEBOUNCE_CYCLES=4, LONG_CYCLES=16); adapts to PB_LONG_PRESS_EN.
module tb_pb_conditioner;

    localparam int DEB  = 4;
    localparam int LONG = 16;
`ifdef PB_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pb_in = 1'b0;
    logic       pb_level, pb_press, pb_release, pb_long;
    logic [7:0] press_cnt;

    pb_conditioner #(.DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG)) dut (
        .clk        (clk),
        .rst        (rst),
        .pb_in      (pb_in),
        .pb_level   (pb_level),
        .pb_press   (pb_press),
        .pb_release (pb_release),
        .pb_long    (pb_long),
        .press_cnt  (press_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;   // 0 press, 1 release, 2 long
        int at;
        int cnt;
    } ev_t;

    ev_t q[$];
    int  tests = 0;
    int  fails = 0;
    int  press_seen = 0;
    int  long_seen = 0;
    logic lvl_m = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int k, input int t, input int cnt);
        ev_t e;
        e.kind = k;
        e.at   = t;
        e.cnt  = cnt;
        q.push_back(e);
    endtask

    task automatic take(input int k);
        ev_t e;
        if (k == 0) press_seen++;
        if (k == 2) long_seen++;
        if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_pulse: kind %0d at cycle %0d, expected none", k, cyc);
            return;
        end
        e = q.pop_front();
        chk("event_kind", k, e.kind);
        chk("event_cycle", cyc, e.at);
        if (e.kind == 0) begin
            lvl_m = 1'b1;
            chk("press_cnt_at_press", int'(press_cnt), e.cnt);
        end else if (e.kind == 1) begin
            lvl_m = 1'b0;
        end
    endtask

    // Monitor: pops the scoreboard whenever a pulse appears, and tracks the expected level.
    always @(negedge clk) begin
        if (!rst) begin
            lvl_m = 1'b0;
        end else begin
            while (q.size() != 0 && q[0].at < cyc) begin
                ev_t m;
                m = q.pop_front();
                tests++;
                fails++;
                $display("FAIL missed_pulse: kind %0d got no pulse, expected at cycle %0d", m.kind, m.at);
            end
            if (pb_press)   take(0);
            if (pb_release) take(1);
            if (pb_long)    take(2);
            chk("pb_level", int'(pb_level), int'(lvl_m));
        end
    end

    task automatic set_at(input int t, input logic v);
        while (cyc < t) @(negedge clk);
        pb_in = v;
    endtask

    task automatic chk_zero(input string tag, input int exp_cnt);
        chk({tag, "_level"},   int'(pb_level),   0);
        chk({tag, "_press"},   int'(pb_press),   0);
        chk({tag, "_release"}, int'(pb_release), 0);
        chk({tag, "_long"},    int'(pb_long),    0);
        chk({tag, "_cnt"},     int'(press_cnt),  exp_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        int c;
        int ps0;
        rst   = 1'b0;
        pb_in = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset", 0);
        rst = 1'b1;
        c = cyc + 3;

        // clean press: pulse 7 sampled cycles after the input change (edge 6)
        set_at(c, 1'b1);
        push(0, c + 7, 1);
        set_at(c + 20, 1'b0);
        push(1, c + 27, 0);
        c += 40;

        // 3-cycle and 4-cycle highs are rejected
        set_at(c, 1'b1);
        set_at(c + 3, 1'b0);
        set_at(c + 15, 1'b1);
        set_at(c + 19, 1'b0);
        set_at(c + 30, 1'b0);
        chk("bounce_press_cnt", int'(press_cnt), 1);
        chk("bounce_level", int'(pb_level), 0);
        c += 40;

        // 5-cycle high is the shortest accepted press
        set_at(c, 1'b1);
        push(0, c + 7, 2);
        set_at(c + 5, 1'b0);
        push(1, c + 12, 0);
        c += 30;

        // long hold with a 2-cycle release glitch
        set_at(c, 1'b1);
        push(0, c + 7, 3);
        if (LONG_EN) push(2, c + 23, 0);
        set_at(c + 12, 1'b0);
        set_at(c + 14, 1'b1);
        set_at(c + 47, 1'b0);
        push(1, c + 54, 0);
        set_at(c + 60, 1'b0);
        chk("long_pulse_count", long_seen, LONG_EN ? 1 : 0);
        c += 70;

        // async reset during PRESS_WAIT, then a fresh press with input held
        set_at(c, 1'b1);
        set_at(c + 4, 1'b1);
        #2 rst = 1'b0;
        #1 chk_zero("rst_presswait", 0);
        set_at(c + 6, 1'b1);
        rst = 1'b1;
        push(0, c + 13, 1);
        // async reset during PRESSED
        set_at(c + 18, 1'b1);
        chk("pressed_level", int'(pb_level), 1);
        #2 rst = 1'b0;
        #1 chk_zero("rst_pressed", 0);
        pb_in = 1'b0;
        set_at(c + 20, 1'b0);
        rst = 1'b1;
        c += 30;

        // 256 clean presses wrap the counter back to 0
        ps0 = press_seen;
        for (int i = 0; i < 256; i++) begin
            set_at(c, 1'b1);
            push(0, c + 7, (i + 1) % 256);
            set_at(c + 8, 1'b0);
            push(1, c + 15, 0);
            c += 16;
        end
        set_at(c + 10, 1'b0);
        chk("press_cnt_wrap", int'(press_cnt), 0);
        chk("press_pulses_256", press_seen - ps0, 256);

        set_at(c + 20, 1'b0);
        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pb_conditioner.md
PB_CONDITIONER -- requirements
Module: pb_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 270000, meaning required stable cycles (10 ms at 27 MHz); legal range 2..2^20-1.
REQ-002 SHALL have parameter LONG_CYCLES, default 27000000, meaning held cycles before a long-press event (1 s at 27 MHz); legal range DEBOUNCE_CYCLES+1..2^26-1.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset (rst=0 resets).
REQ-005 SHALL have port pb_in  input  1  raw, asynchronous, bouncing pushbutton, 1 = pressed.
REQ-006 SHALL have port pb_level  output  1  debounced button level, registered; feeds the traffic-light stage pb0 input.
REQ-007 SHALL have port pb_press  output  1  one-cycle pulse on debounced press.
REQ-008 SHALL have port pb_release  output  1  one-cycle pulse on debounced release.
REQ-009 SHALL have port pb_long  output  1  one-cycle pulse when a press has been held LONG_CYCLES.
REQ-010 SHALL have port press_cnt  output  8  count of debounced presses, wraps 255->0.

Function
REQ-011 SHALL pass pb_in through a 2-flop synchronizer (s1, s2); only s2 is used downstream.
REQ-012 SHALL implement FSM states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT with one shared debounce counter dcnt.
REQ-013 SHALL, in IDLE with s2=1, go to PRESS_WAIT with dcnt=0; otherwise stay.
REQ-014 SHALL, in PRESS_WAIT, return to IDLE on s2=0 (glitch rejected, no output change); else increment dcnt, and on dcnt==DEBOUNCE_CYCLES-1 go to PRESSED.
REQ-015 SHALL, on PRESS_WAIT->PRESSED, set pb_level=1, pulse pb_press for exactly one cycle, increment press_cnt, clear long counter lcnt.
REQ-016 SHALL, with pb_in rising stably before edge 0, show pb_press=1 in the cycle following edge DEBOUNCE_CYCLES+2.
REQ-017 SHALL, in PRESSED, go to RELEASE_WAIT with dcnt=0 on s2=0.
REQ-018 SHALL, in RELEASE_WAIT, return to PRESSED on s2=1 (no release event, lcnt retained); else increment dcnt, and on dcnt==DEBOUNCE_CYCLES-1 go to IDLE, set pb_level=0, pulse pb_release one cycle.
REQ-019 SHALL increment lcnt each cycle in PRESSED and RELEASE_WAIT, saturating at LONG_CYCLES; pb_long pulses once when lcnt reaches LONG_CYCLES-1; never again in the same press.
REQ-020 SHALL never assert pb_press, pb_release, pb_long for more than one consecutive cycle; pb_press and pb_release never together.
REQ-021 SHALL keep pb_level constant except at REQ-015/REQ-018 transitions.

Reset
REQ-022 SHALL, on rst=0 at any time including mid-debounce or mid-press, immediately force state IDLE, s1=s2=0, dcnt=0, lcnt=0, pb_level=0, pb_press=0, pb_release=0, pb_long=0, press_cnt=0.
REQ-023 SHALL, after rst deasserts with pb_in held 1, treat it as a fresh press (full REQ-016 latency).

Configuration
REQ-024 SHALL, with macro PB_LONG_PRESS_EN defined, implement lcnt and pb_long per REQ-019.
REQ-025 SHALL, without PB_LONG_PRESS_EN, omit lcnt logic entirely and drive pb_long constant 0; all other behaviour unchanged.

Verification (bench uses DEBOUNCE_CYCLES=4, LONG_CYCLES=16, macro defined unless stated)
REQ-026 SHALL cover: pb_in 0->1 held at edge 0 -> pb_press=1 only after edge 6, pb_level=1 thereafter, press_cnt=1.
REQ-027 SHALL cover: pb_in 1 for 3 cycles then 0 -> no pb_press, pb_level stays 0, press_cnt=0.
REQ-028 SHALL cover: press held 30 cycles -> single pb_long pulse 16 cycles after pb_press; release 2-cycle low glitch mid-hold -> no pb_release; final stable release -> one pb_release, pb_level=0.
REQ-029 SHALL cover: 256 clean presses -> press_cnt returns to 0 with 256 pb_press pulses.
REQ-030 SHALL cover: rst=0 asserted during PRESS_WAIT and during PRESSED -> all outputs 0 asynchronously, press_cnt=0; macro undefined -> pb_long never 1 across a 40-cycle hold.
